// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
//   Shared definitions for the seven-segment scan driver:
//     - active-low segment patterns {a,b,c,d,e,f,g} for digits 0..9,
//       the blank pattern and the overflow dash
//     - converter FSM state type (IDLE / SHIFT / LOAD)
//     - clog2 and pow10 constant functions used for sizing and MAX_VAL
// -----------------------------------------------------------------------------
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // 10^n as a 64-bit constant (n <= 8 in practice).
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/sevseg_scan_driver_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble binary-to-BCD converter with a valid/ready input.
//
//   Handshake: the converter is ready exactly when o_state == IDLE. A value is
//   transferred on a rising clk edge where i_valid is high and the state is
//   IDLE; i_valid is ignored in every other state and the source must hold
//   its value until it sees the transfer.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_value        binary value to convert
//     i_valid        i_value is valid
//     o_done         one-cycle pulse (LOAD state): o_bcd/o_overflow are final
//     o_bcd          N_DIGITS BCD digits, digit 0 in bits [3:0]
//     o_overflow     value captured at the transfer exceeded 10^N_DIGITS-1
//     o_state        current FSM state (also the ready indication)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     i_value,
    input  logic                  i_valid,
    output logic                  o_done,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic                  o_overflow,
    output conv_state_t           o_state
);

    // One guard nibble above the visible digits keeps the adjust step well
    // defined for out-of-range values (those are shown as dashes anyway).
    localparam int          SCR_W   = 4*N_DIGITS + 4;
    localparam int          CNT_W   = clog2(DATA_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;
    localparam logic [63:0] IN_MAX  = (64'd1 << DATA_W) - 64'd1;
    localparam bit          OVF_EN  = (IN_MAX > MAX_VAL);

    conv_state_t              r_state;
    conv_state_t              w_next_state;
    logic [DATA_W-1:0]        r_shift;
    logic [SCR_W-1:0]         r_scratch;
    logic [CNT_W-1:0]         r_count;
    logic                     r_ovf;
    logic                     w_accept;
    logic                     w_value_ovf;
    logic [SCR_W-1:0]         w_adj;
    logic [SCR_W+DATA_W-1:0]  w_shifted;

    assign w_accept = (r_state == IDLE) && i_valid;

    // When no input value can exceed MAX_VAL the comparison is tied off.
    generate
        if (OVF_EN) begin : g_ovf
            assign w_value_ovf = (64'(i_value) > MAX_VAL);
        end else begin : g_no_ovf
            assign w_value_ovf = 1'b0;
        end
    endgenerate

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int n = 0; n < SCR_W/4; n++) begin
            if (r_scratch[4*n +: 4] >= 4'd5) begin
                w_adj[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_adj, r_shift} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_valid) w_next_state = SHIFT;
            SHIFT:   if (r_count == CNT_W'(1)) w_next_state = LOAD;
            LOAD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= i_value;
            r_scratch <= '0;
            r_count   <= CNT_W'(DATA_W);
            r_ovf     <= w_value_ovf;
        end else if (r_state == SHIFT) begin
            {r_scratch, r_shift} <= w_shifted;
            r_count              <= r_count - CNT_W'(1);
        end
    end

    assign o_done     = (r_state == LOAD);
    assign o_bcd      = r_scratch[4*N_DIGITS-1:0];
    assign o_overflow = r_ovf;
    assign o_state    = r_state;

endmodule

// File: rtl/sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevseg_scan_driver
//   Converts a binary value to BCD (sequential double-dabble) and scans it
//   onto N_DIGITS common-anode seven-segment digits, each lit for
//   2^DWELL_W clock cycles.
//
//   Ports:
//     clk_100mhz      system clock
//     reset_n         asynchronous active-low reset
//     value_i         unsigned binary value to display
//     value_valid     value_i is valid
//     value_ready     converter idle, a value is taken when valid && ready
//     anode_activate  active-low digit enables, bit N_DIGITS-1 = leftmost
//     led_out         active-low segments {a,b,c,d,e,f,g}
//     overflow        last accepted value exceeded 10^N_DIGITS-1
//
//   Build option: define SEVSEG_LZB_EN to blank leading zeros (the rightmost
//   digit is always shown; overflow dashes are unaffected).
// -----------------------------------------------------------------------------
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 16,
    parameter int DWELL_W  = 18
) (
    input  logic                clk_100mhz,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   value_i,
    input  logic                value_valid,
    output logic                value_ready,
    output logic [N_DIGITS-1:0] anode_activate,
    output logic [6:0]          led_out,
    output logic                overflow
);

    localparam int                IDX_W = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

    conv_state_t           w_conv_state;
    logic                  w_done;
    logic [4*N_DIGITS-1:0] w_bcd;
    logic                  w_ovf;

    logic [4*N_DIGITS-1:0] r_disp;
    logic                  r_ovf;
    logic [DWELL_W-1:0]    r_dwell;
    logic [IDX_W-1:0]      r_idx;
    logic [N_DIGITS-1:0]   r_anode;
    logic [6:0]            r_led;

    logic [3:0]            w_nib;
    logic [N_DIGITS-1:0]   w_anode;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [6:0]            w_led;

    bin2bcd_seq #(
        .N_DIGITS (N_DIGITS),
        .DATA_W   (DATA_W)
    ) u_bin2bcd (
        .clk        (clk_100mhz),
        .rst_n      (reset_n),
        .i_value    (value_i),
        .i_valid    (value_valid),
        .o_done     (w_done),
        .o_bcd      (w_bcd),
        .o_overflow (w_ovf),
        .o_state    (w_conv_state)
    );

    assign value_ready = (w_conv_state == IDLE);

    // Display register only changes on the done pulse, never mid-conversion.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= '0;
            r_ovf  <= 1'b0;
        end else if (w_done) begin
            r_disp <= w_bcd;
            r_ovf  <= w_ovf;
        end
    end

    // Dwell counter wraps naturally; the index advances on its terminal count.
    // The >= compare keeps the index inside 0..N_DIGITS-1 for any N_DIGITS.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
            r_idx   <= '0;
        end else begin
            r_dwell <= r_dwell + DWELL_W'(1);
            if (&r_dwell) begin
                if (r_idx >= IDX_W'(N_DIGITS - 1)) begin
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef SEVSEG_LZB_EN
    // w_lz[k]: every digit from the leftmost through index k is zero.
    logic [N_DIGITS-1:0] w_lz;
    generate
        for (genvar k = 0; k < N_DIGITS - 1; k++) begin : g_lz
            assign w_lz[k] = (r_disp[4*N_DIGITS-1 -: 4*(k+1)] == '0);
        end
    endgenerate
    assign w_lz[N_DIGITS-1] = 1'b0;
`endif

    // Index k (0 = leftmost) selects BCD nibble N_DIGITS-1-k and pulls anode
    // bit N_DIGITS-1-k low.
    always_comb begin
        w_nib   = 4'd0;
        w_anode = '1;
        w_blank = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib   = r_disp[4*(N_DIGITS-1-k) +: 4];
                w_anode = ~(ONE_HOT0 << (N_DIGITS - 1 - k));
`ifdef SEVSEG_LZB_EN
                w_blank = w_lz[k];
`else
                w_blank = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        w_seg = SEG_BLANK;
        case (w_nib)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        w_led = w_seg;
        if (r_ovf) begin
            w_led = SEG_DASH;
        end else if (w_blank) begin
            w_led = SEG_BLANK;
        end
    end

    // Anode and segments are registered together so they switch on one edge.
    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_anode <= '1;
            r_led   <= SEG_BLANK;
        end else begin
            r_anode <= w_anode;
            r_led   <= w_led;
        end
    end

    assign anode_activate = r_anode;
    assign led_out        = r_led;
    assign overflow       = r_ovf;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevseg_scan_driver
//   Two instances share clock, reset and the value bus: a 4-digit and a
//   5-digit driver, both 16-bit input with a 4-cycle dwell. The reference
//   model keeps the last accepted value per instance and derives each
//   digit's expected segments with decimal arithmetic.
// -----------------------------------------------------------------------------
module tb_sevseg_scan_driver;

    localparam int DW    = 16;
    localparam int DWELL = 2;
    localparam int DCYC  = 1 << DWELL;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] value;
    logic          valid;
    logic          ready4, ready5, ovf4, ovf5;
    logic [3:0]    an4;
    logic [4:0]    an5;
    logic [6:0]    led4, led5;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    // Reference model state: last accepted value and overflow per instance.
    longint mv4 = 0, mv5 = 0;
    bit     mo4 = 0, mo5 = 0;
    bit     sel = 0;

    always #5 clk = ~clk;

    sevseg_scan_driver #(.N_DIGITS(4), .DATA_W(DW), .DWELL_W(DWELL)) dut4 (
        .clk_100mhz     (clk),
        .reset_n        (reset_n),
        .value_i        (value),
        .value_valid    (valid),
        .value_ready    (ready4),
        .anode_activate (an4),
        .led_out        (led4),
        .overflow       (ovf4)
    );

    sevseg_scan_driver #(.N_DIGITS(5), .DATA_W(DW), .DWELL_W(DWELL)) dut5 (
        .clk_100mhz     (clk),
        .reset_n        (reset_n),
        .value_i        (value),
        .value_valid    (valid),
        .value_ready    (ready5),
        .anode_activate (an5),
        .led_out        (led5),
        .overflow       (ovf5)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mon_an();
        return sel ? {3'b111, an5} : {4'hF, an4};
    endfunction

    function automatic logic [6:0] mon_led();
        return sel ? led5 : led4;
    endfunction

    function automatic logic [6:0] exp_seg(input longint v, input bit o, input int n, input int k);
        longint p;
        p = 1;
        for (int i = 0; i < n - 1 - k; i++) p = p * 10;
        if (o) return 7'b1111110;
`ifdef SEVSEG_LZB_EN
        if (k < n - 1 && v < p) return 7'b1111111;
`endif
        return seg_tab[int'((v / p) % 10)];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sync to the next anode change, then follow 2*n dwells checking the
    // anode one-hot order, dwell length and segment pattern of each digit.
    task automatic check_scan(input string tag, input int start_k);
        int          n, k, cnt, zeros, j0;
        logic [7:0]  prev;
        longint      v;
        bit          o;
        n = sel ? 5 : 4;
        v = sel ? mv5 : mv4;
        o = sel ? mo5 : mo4;
        prev = mon_an();
        cnt = 0;
        while (mon_an() == prev && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_sync"}, 64'(cnt < 64), 64'd1);
        zeros = 0;
        j0 = 0;
        for (int j = 0; j < 8; j++) begin
            if (mon_an()[j] == 1'b0) begin
                zeros++;
                j0 = j;
            end
        end
        check({tag, "_onehot"}, 64'(zeros), 64'd1);
        check({tag, "_valid_digit"}, 64'(j0 < n), 64'd1);
        k = (j0 < n) ? (n - 1 - j0) : 0;
        if (start_k >= 0) check({tag, "_start_idx"}, 64'(k), 64'(start_k));
        for (int d = 0; d < 2 * n; d++) begin
            for (int c = 0; c < DCYC; c++) begin
                check({tag, "_anode"}, 64'(mon_an()), 64'(8'hFF & ~(8'd1 << (n - 1 - k))));
                check({tag, "_seg"}, 64'(mon_led()), 64'(exp_seg(v, o, n, k)));
                @(negedge clk);
            end
            k = (k + 1) % n;
        end
    endtask

    // Raise valid, hold until the converter is ready, drop after the transfer.
    task automatic send(input logic [DW-1:0] v);
        int cnt;
        @(negedge clk);
        value = v;
        valid = 1'b1;
        cnt = 0;
        while (!ready4 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("send_ready_timeout", 64'(cnt < 200), 64'd1);
        @(negedge clk);
        valid = 1'b0;
        check("busy_after_accept", 64'(ready4), 64'd0);
        mv4 = v;
        mo4 = (v > 9999);
        mv5 = v;
        mo5 = (v > 99999);
    endtask

    task automatic wait_idle(input string tag, input int exp_busy);
        int busy;
        busy = 0;
        while (!ready4 && busy < 200) begin
            @(negedge clk);
            busy++;
        end
        check({tag, "_idle_timeout"}, 64'(busy < 200), 64'd1);
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, 64'(busy), 64'(exp_busy));
        check({tag, "_ready5"}, 64'(ready5), 64'd1);
        check({tag, "_ovf4"}, 64'(ovf4), 64'(mo4));
        check({tag, "_ovf5"}, 64'(ovf5), 64'(mo5));
    endtask

    task automatic scan_both(input string tag);
        sel = 1'b0;
        check_scan({tag, "_n4"}, -1);
        sel = 1'b1;
        check_scan({tag, "_n5"}, -1);
        sel = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an4"}, 64'(an4), 64'hF);
        check({tag, "_an5"}, 64'(an5), 64'h1F);
        check({tag, "_led4"}, 64'(led4), 64'h7F);
        check({tag, "_led5"}, 64'(led5), 64'h7F);
        check({tag, "_ready"}, 64'(ready4), 64'd1);
        check({tag, "_ovf"}, 64'(ovf4), 64'd0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        reset_n = 1'b1;
        mv4 = 0; mo4 = 0; mv5 = 0; mo5 = 0;
        sel = 1'b0;
        check_scan({tag, "_after"}, 0);
    endtask

    initial begin
        logic [DW-1:0] rv;
        reset_n = 1'b0;
        valid   = 1'b0;
        value   = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        sel = 1'b0;
        check_scan("por_first", 0);

        send(16'd1234);
        wait_idle("v1234", DW + 1);
        scan_both("v1234");

        send(16'd7);
        wait_idle("v7", DW + 1);
        scan_both("v7");

        send(16'd0);
        wait_idle("v0", DW + 1);
        scan_both("v0");

        send(16'd65535);
        wait_idle("v65535", DW + 1);
        scan_both("v65535");

        send(16'd9999);
        wait_idle("v9999", DW + 1);
        scan_both("v9999");

        send(16'd10000);
        wait_idle("v10000", DW + 1);
        scan_both("v10000");

        // A one-cycle valid pulse while busy must be ignored.
        send(16'd1234);
        value = 16'd42;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_idle("pulse42", -1);
        scan_both("pulse42");

        // Holding valid across the busy window gets the value accepted.
        send(16'd1234);
        value = 16'd42;
        valid = 1'b1;
        send(16'd42);
        wait_idle("hold42", DW + 1);
        scan_both("hold42");

        pulse_reset("rst_scan");

        // Reset during SHIFT aborts the conversion.
        send(16'd4321);
        repeat (3) @(negedge clk);
        pulse_reset("rst_shift");
        sel = 1'b1;
        check_scan("rst_shift_n5", -1);
        sel = 1'b0;

        for (int i = 0; i < 6; i++) begin
            rv = 16'($urandom_range(0, 65535));
            send(rv);
            wait_idle("rand", DW + 1);
            scan_both("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Parametrised successor to the fixed 4-digit display driver.
- Accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential double-dabble engine, so there are no combinational divide/modulo chains.
- Time-multiplexes N_DIGITS common-anode digits at a programmable dwell period.
- Sits between the processor result bus and the board seven-segment pins.

Parameters:
- N_DIGITS, 4: number of digits scanned (2..8).
- DATA_W, 16: width of the input binary value (4..32).
- DWELL_W, 18: each digit is lit for 2^DWELL_W clk_100mhz cycles.

Ports:
- clk_100mhz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- value_i  in  DATA_W  unsigned binary value to display.
- value_valid  in  1  value_i is valid.
- value_ready  out  1  converter idle; can accept a value.
- anode_activate  out  N_DIGITS  active-low digit enables. Bit N_DIGITS-1 is the leftmost (most significant) digit.
- led_out  out  7  active-low segments {a,b,c,d,e,f,g}.
- overflow  out  1  last accepted value exceeded 10^N_DIGITS-1.

Behaviour:
- Reset (async assert, sync deassert by design):
  - FSM goes to IDLE and value_ready=1.
  - Display BCD register cleared to 0 and overflow=0.
  - Dwell counter and digit index cleared to 0.
  - anode_activate=all ones; led_out=7'b1111111.
- Converter FSM:
  - States: IDLE, SHIFT, LOAD.
  - IDLE: value_ready=1. A transfer happens when value_valid && value_ready on a rising edge. That edge captures value_i into a shift register, clears the BCD scratch register (4*N_DIGITS bits plus 4 guard bits), loads the iteration count DATA_W, and goes to SHIFT.
  - SHIFT: one double-dabble iteration per cycle. Every scratch nibble >=5 gets +3, then {scratch,shift} shifts left by 1. After DATA_W iterations go to LOAD.
  - LOAD: copy scratch to the display register and update overflow, then return to IDLE.
  - value_ready=0 in SHIFT and LOAD. value_valid is ignored while busy; the source holds its value.
  - Latency: new digits are visible in the display register DATA_W+1 cycles after the accept edge.
  - The display register never changes mid-conversion, so there is no partial-value flicker.
- Overflow:
  - Evaluated at the accept edge by comparing against the localparam MAX_VAL=10^N_DIGITS-1.
  - If true: overflow=1 and all digits show dash 7'b1111110 until the next accepted in-range value.
  - If 2^DATA_W-1 <= MAX_VAL, the comparison is tied off and overflow stays 0.
- Scan:
  - Dwell counter counts 0..2^DWELL_W-1 and wraps.
  - At the terminal count the digit index increments, wrapping from N_DIGITS-1 to 0. Non-power-of-two N_DIGITS must never select a nonexistent digit.
  - Index 0 is the leftmost digit and drives anode bit N_DIGITS-1 low; index k drives bit N_DIGITS-1-k low.
  - Exactly one anode bit is low at any time after reset.
  - anode_activate and led_out are registered outputs, updated one cycle after an index change. The anode and its segment pattern always change on the same edge.
- Segment encoding (active low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - BCD codes 10-15 cannot occur; the decoder default is blank 1111111.
- Reset mid-conversion aborts the conversion, clears the display register, and blanks the outputs.

Optional Feature:
- Macro SEVSEG_LZB_EN enables leading-zero blanking.
- Defined: leading zeros are blanked (led_out=1111111) left of the first nonzero digit. The rightmost digit is always shown, so 0 displays as a single "0". Overflow dashes are unaffected.
- Undefined: all digits show, including leading zeros ("0007").

Decomposition:
- Package sevseg_pkg holds:
  - the seven-segment constant table (SEG_0..SEG_9, SEG_BLANK, SEG_DASH),
  - the FSM state typedef (IDLE/SHIFT/LOAD),
  - a clog2 function,
  - a pow10 constant function for MAX_VAL.
- One natural sub-module, bin2bcd_seq: the double-dabble FSM with the handshake. Its output is the BCD digits plus a done pulse.
- The scan counter, digit mux and segment decode stay in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-scan -> anode_activate=4'b1111, led_out=7'b1111111, value_ready=1, overflow=0 immediately (async). After release, the first dwell shows "0000" with anode 0111 first.
- Basic conversion (DWELL_W=2): send 1234 -> value_ready low for 17 cycles. The display register then reads BCD 0x1234, and the scan cycles anodes 0111/1011/1101/1110 with led_out 1001111/0010010/0000110/1001100, each for 4 cycles.
- Overflow: N_DIGITS=4, send 65535 -> overflow=1 and all digits 1111110. Then send 9999 -> overflow=0, display "9999".
- Odd width/depth: N_DIGITS=5, DATA_W=16, send 65535 -> digits 6,5,5,3,5. The index wraps from 4 to 0 and never asserts an invalid anode pattern.
- Handshake: pulse value_valid with 42 while busy converting 1234 -> 42 is ignored and the display ends at 1234. Holding 42 valid until ready -> 42 is accepted and shown.
- SEVSEG_LZB_EN defined, send 7 -> three blank digits and rightmost 0001111. Send 0 -> rightmost 0000001, others blank. Reset during SHIFT -> outputs blank and no stale digits after release.
